// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_AW    = 5;
    localparam int RF_NRD   = 2;
    localparam int ZERO_IDX = 0;

    // Ceiling log2, used to size counters that must hold the value n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard with a live busy counter and read-port lookup.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW  = RF_AW,
    parameter int NRD = RF_NRD,
    localparam int DEPTH = 1 << AW,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr0,
    input  logic [AW-1:0]     clr_addr0,
    input  logic              clr1,
    input  logic [AW-1:0]     clr_addr1,
    input  logic              set,
    input  logic [AW-1:0]     set_addr,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NRD-1:0]    fwd,
    output logic [NRD-1:0]    rbusy,
    output logic [CW-1:0]     busy_cnt
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    n_set;
    logic [CW-1:0]    n_clr;
    logic [CW-1:0]    cnt_nxt;

    // Next busy vector: writes clear, issue sets, and set overrides clear.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < DEPTH; j++) begin
            if (clr0 && clr_addr0 == AW'(j)) busy_nxt[j] = 1'b0;
            if (clr1 && clr_addr1 == AW'(j)) busy_nxt[j] = 1'b0;
            if (set && set_addr == AW'(j))   busy_nxt[j] = 1'b1;
        end
    end

    // Counter update from actual per-bit transitions, so a dual clear of one
    // address or a set/clear race on one address is counted correctly.
    always_comb begin
        n_set = '0;
        n_clr = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (busy_nxt[j] && !busy[j]) n_set = n_set + CW'(1);
            if (!busy_nxt[j] && busy[j]) n_clr = n_clr + CW'(1);
        end
        cnt_nxt = busy_cnt + n_set - n_clr;
    end

    // Busy state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read-port busy lookup; a forwarded write hides the pending hazard.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = busy[raddr[i*AW +: AW]] && !fwd[i];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two synchronous writes
// (port 1 wins collisions), optional bypass, zero register and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = RF_AW,
    parameter int NRD      = RF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_addr,
    output logic [AW:0]       busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DW-1:0]  mem [DEPTH];
    logic           we0_eff;
    logic           we1_eff;
    logic           issue_eff;
    logic [NRD-1:0] fwd;

    // Writes and issues are qualified by reset (so nothing forwards while in
    // reset) and dropped when they target the hard-wired zero register.
    assign we0_eff   = we0 && rst_n && !(ZERO_EN && waddr0 == AW'(ZERO_IDX));
    assign we1_eff   = we1 && rst_n && !(ZERO_EN && waddr1 == AW'(ZERO_IDX));
    assign issue_eff = issue_valid && rst_n && !(ZERO_EN && issue_addr == AW'(ZERO_IDX));

    // Storage; port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else begin
            if (we0_eff) mem[waddr0] <= wdata0;
            if (we1_eff) mem[waddr1] <= wdata1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit0;
        logic          hit1;
        logic [DW-1:0] rd;

        assign ra     = raddr[i*AW +: AW];
        assign hit0   = BYP_EN && we0_eff && waddr0 == ra;
        assign hit1   = BYP_EN && we1_eff && waddr1 == ra;
        assign fwd[i] = hit0 || hit1;

        // Read mux: storage, overridden by forwarded write data (port 1 first).
        always_comb begin
            rd = mem[ra];
            if (hit1)      rd = wdata1;
            else if (hit0) rd = wdata0;
            if (ZERO_EN && ra == AW'(ZERO_IDX)) rd = '0;
        end

        assign rdata[i*DW +: DW] = rd;
    end

    rf_scoreboard #(
        .AW  (AW),
        .NRD (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr0      (we0_eff),
        .clr_addr0 (waddr0),
        .clr1      (we1_eff),
        .clr_addr1 (waddr1),
        .set       (issue_eff),
        .set_addr  (issue_addr),
        .raddr     (raddr),
        .fwd       (fwd),
        .rbusy     (rbusy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .we0         (we0),
        .waddr0      (waddr0),
        .wdata0      (wdata0),
        .we1         (we1),
        .waddr1      (waddr1),
        .wdata1      (wdata1),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_cnt    (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        issue_valid = 1'b0; issue_addr = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd(5'd0, 5'd0);

        // 1. Reset: reads are zero, even with a write driven during reset.
        for (int a = 0; a < 32; a += 4) begin
            @(negedge clk);
            rd(5'(a), 5'(a + 1));
            #1;
            chk("rst_rdata", {32'b0, rdata}, 64'd0);
            chk("rst_cnt", {58'b0, busy_cnt}, 64'd0);
        end
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; rd(5'd5, 5'd5);
        #1;
        chk("rst_nobypass", {32'b0, rdata}, 64'd0);
        chk("rst_rbusy", {62'b0, rbusy}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; rd(5'd5, 5'd6);
        #1;
        chk("wr_bypass", {32'b0, rdata[31:0]}, 64'hDEADBEEF);
        chk("wr_other", {32'b0, rdata[63:32]}, 64'd0);
        @(posedge clk); #1;
        idle();
        #1;
        chk("wr_stored", {32'b0, rdata[31:0]}, 64'hDEADBEEF);
        chk("wr_nonbusy_cnt", {58'b0, busy_cnt}, 64'd0);

        // 2. Collision: port 1 wins both in bypass and in storage.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
        rd(5'd7, 5'd7);
        #1;
        chk("coll_bypass", {32'b0, rdata[63:32]}, 64'h2222);
        @(posedge clk); #1;
        idle();
        #1;
        chk("coll_stored", rdata, {32'h2222, 32'h2222});

        // 3. Zero register ignores writes and issues.
        @(negedge clk);
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        rd(5'd0, 5'd5);
        #1;
        chk("zero_same", {32'b0, rdata[31:0]}, 64'd0);
        chk("zero_rbusy", {62'b0, rbusy}, 64'd0);
        @(posedge clk); #1;
        idle();
        #1;
        chk("zero_next", {32'b0, rdata[31:0]}, 64'd0);
        chk("zero_cnt", {58'b0, busy_cnt}, 64'd0);
        chk("zero_rbusy_next", {62'b0, rbusy}, 64'd0);

        // 4. Scoreboard lifecycle.
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 5'd3; rd(5'd3, 5'd4);
        #1;
        chk("issue_not_visible", {62'b0, rbusy}, 64'd0);
        @(posedge clk); #1;
        issue_addr = 5'd4;
        chk("sb_cnt1", {58'b0, busy_cnt}, 64'd1);
        @(posedge clk); #1;
        idle();
        #1;
        chk("sb_cnt2", {58'b0, busy_cnt}, 64'd2);
        chk("sb_rbusy11", {62'b0, rbusy}, 64'b11);
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3333_3333;
        #1;
        chk("sb_wr_rbusy", {62'b0, rbusy}, 64'b10);
        chk("sb_wr_rdata", {32'b0, rdata[31:0]}, 64'h3333_3333);
        @(posedge clk); #1;
        idle();
        #1;
        chk("sb_cnt_after", {58'b0, busy_cnt}, 64'd1);
        chk("sb_rbusy_after", {62'b0, rbusy}, 64'b10);

        // 5. Set-wins race on r9.
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 5'd9;
        @(posedge clk); #1;
        idle();
        #1;
        chk("race_pre_cnt", {58'b0, busy_cnt}, 64'd2);
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 5'd9;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h9999;
        rd(5'd9, 5'd4);
        #1;
        chk("race_fwd_rbusy", {62'b0, rbusy}, 64'b10);
        @(posedge clk); #1;
        idle();
        #1;
        chk("race_cnt", {58'b0, busy_cnt}, 64'd2);
        chk("race_rbusy", {62'b0, rbusy}, 64'b11);
        chk("race_rdata", {32'b0, rdata[31:0]}, 64'h9999);

        // Dual clear of r4 by both ports decrements once.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h4000;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4001;
        @(posedge clk); #1;
        idle();
        #1;
        chk("dual_clr_cnt", {58'b0, busy_cnt}, 64'd1);
        chk("dual_clr_data", {32'b0, rdata[63:32]}, 64'h4001);

        // 6. Ten registers busy, then asynchronous reset between edges.
        for (int a = 10; a < 19; a++) begin
            @(negedge clk);
            issue_valid = 1'b1; issue_addr = 5'(a);
        end
        @(posedge clk); #1;
        idle();
        #1;
        chk("ten_busy", {58'b0, busy_cnt}, 64'd10);
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hAAAA;
        we1 = 1'b1; waddr1 = 5'd21; wdata1 = 32'hBBBB;
        rd(5'd5, 5'd9);
        #1;
        chk("pre_rst_rbusy", {62'b0, rbusy}, 64'b10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", {58'b0, busy_cnt}, 64'd0);
        chk("mid_rst_rbusy", {62'b0, rbusy}, 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rd(5'd20, 5'd21);
        #1;
        chk("lost_writes", rdata, 64'd0);
        @(negedge clk);
        rd(5'd7, 5'd12);
        #1;
        chk("post_rst_regs", rdata, 64'd0);
        chk("post_rst_cnt", {58'b0, busy_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the next CPU generation.
- Provides NRD combinational read ports and two synchronous write ports (ALU/EX path = port 0, MEM/late path = port 1).
- Optional write-to-read bypass, hard-wired zero register, and a per-register busy scoreboard with a live busy counter for pipeline hazard detection.
- Sits between decode (read/issue) and writeback, replacing the single-port 32x32 register file.

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW registers
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never marked busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
raddr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
rdata  out  NRD*DW  packed read data, combinational
rbusy  out  NRD  busy flag of each read address, combinational
we0  in  1  write enable, port 0
waddr0  in  AW  write address, port 0
wdata0  in  DW  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  AW  write address, port 1
wdata1  in  DW  write data, port 1
issue_valid  in  1  mark issue_addr busy (instruction with destination issued)
issue_addr  in  AW  destination register being issued
busy_cnt  out  AW+1  number of registers currently busy (registered)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers, all busy bits and busy_cnt clear to 0.
  - rdata therefore reads 0 and rbusy reads 0 while in reset.
- Write timing: on posedge clk, if weK, reg[waddrK] <= wdataK. Write-to-read latency is one cycle, or zero cycles with BYPASS=1.
- Write collision: both ports target the same address in the same cycle -> port 1 wins.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 with no bypass.
  - issue_addr=0 is ignored.
  - rbusy for address 0 is always 0.
- Read data: rdata[i] = reg[raddr[i]].
- Bypass (BYPASS=1), applied to rdata[i]:
  - If we1 && waddr1==raddr[i] -> wdata1.
  - Else if we0 && waddr0==raddr[i] -> wdata0.
  - The zero-register rule overrides both.
- Scoreboard, evaluated on posedge clk:
  - Write on port K clears busy[waddrK].
  - issue_valid sets busy[issue_addr].
  - Set and clear of the same address in the same cycle -> set wins (a new producer supersedes the old one).
  - A write to a non-busy register is legal; busy stays 0.
- rbusy:
  - rbusy[i] = busy[raddr[i]].
  - With BYPASS=1, rbusy[i] is forced to 0 when a same-cycle write matches raddr[i], because the data is already being forwarded.
  - A same-cycle issue does not affect rbusy; it becomes visible next cycle.
- busy_cnt:
  - Next value = current + (number of 0->1 busy transitions) - (number of 1->0 transitions), computed from the actual per-bit next state.
  - Range 0..2**AW (0..2**AW-1 when ZERO_REG=1); never wraps.
  - Dual-clear of one address counts once.
- No X propagation: every output is defined for any input combination once out of reset.

Decomposition:
- regfile_pkg holds:
  - default constants RF_DW=32, RF_AW=5, RF_NRD=2;
  - a localparam function clog2 for counter sizing;
  - a register-index constant ZERO_IDX=0.
- One sub-module, rf_scoreboard (busy bit vector + busy_cnt + rbusy lookup), instantiated once.
- Storage, write arbitration and bypass mux stay in regfile_mp.

Test Plan:
1. Reset and basic write/read:
   - Stimulus: hold rst_n=0 and sweep raddr. Release, then we0=1, waddr0=5, wdata0=32'hDEADBEEF for one cycle, then read raddr[0]=5.
   - Required: rdata=0 and busy_cnt=0 during reset; 32'hDEADBEEF after the write cycle.
2. Same-address write collision:
   - Stimulus: we0=1/waddr0=7/wdata0=32'h1111 and we1=1/waddr1=7/wdata1=32'h2222 in the same cycle, with raddr[1]=7.
   - Required: same-cycle bypass returns 32'h2222; after the edge reg7=32'h2222.
3. Zero register:
   - Stimulus: we1=1, waddr1=0, wdata1=32'hFFFF_FFFF; issue_valid=1, issue_addr=0.
   - Required: rdata for address 0 = 0 in that cycle and the next; rbusy=0; busy_cnt unchanged.
4. Scoreboard lifecycle:
   - Stimulus: issue r3, then r4 (busy_cnt 1 -> 2). Then write r3 via port 0 while raddr[0]=3.
   - Required: rbusy[0]=0 and rdata=write value in the write cycle; busy_cnt=1 after the edge.
5. Set-wins race:
   - Stimulus: r9 busy; in one cycle issue_valid on r9 and we1 on r9.
   - Required: busy[9] stays 1; busy_cnt unchanged; reg9 updated.
6. Reset mid-operation:
   - Stimulus: with 10 registers busy and writes in flight, pulse rst_n low asynchronously between clock edges.
   - Required: busy_cnt, rbusy and all rdata go to 0 immediately, and the in-flight writes are lost.
